// File: rtl/mux_pkg.sv
// Shared constants for the N:1 registered multiplexer and its arbiter.
package mux_pkg;

  // Operating modes of the multiplexer.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Largest channel count the multiplexer is built for.
  localparam int MAX_N = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-priority encoder: finds the first requesting index at or after ptr,
// wrapping from N-1 back to 0. Works for any N, not only powers of two.
module rr_priority_pick #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] idx;

  // Walk the channels starting at ptr; the one-bit-wider sum lets the wrap stay exact for odd N.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(off);
      if (sum >= (SEL_W+1)'(N)) begin
        sum = sum - (SEL_W+1)'(N);
      end
      idx = sum[SEL_W-1:0];
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N:1 multiplexer with a registered output stage and valid/ready on every side.
// Fixed mode routes the selected channel; round-robin mode arbitrates fairly.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] ch_data [N];
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_ptr_next;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] accept_idx;
  logic             gnt_any;
  logic             sel_ok;
  logic             load;
  logic             accept;

  rr_priority_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The output register can take a word when empty or when its word leaves this cycle;
  // holding reset low blocks every transfer.
  assign load   = rst_n && (!out_valid || out_ready);
  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N));
  assign accept = |(in_valid & in_ready);

  // Split the flat input bus into one word per channel.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Raise at most one ready bit: the selected channel in fixed mode, the granted one in round-robin.
  always_comb begin
    in_ready   = '0;
    accept_idx = '0;
    if (mode == MODE_FIXED) begin
      if (sel_ok) begin
        in_ready[sel] = load;
        accept_idx    = sel;
      end
    end else if (gnt_any) begin
      in_ready[gnt_idx] = load;
      accept_idx        = gnt_idx;
    end
  end

  // The pointer moves just past the winner so it gets lowest priority next time.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (accept && (mode == MODE_RR)) begin
      if ({1'b0, accept_idx} == (SEL_W+1)'(N-1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = accept_idx + SEL_W'(1);
      end
    end
  end

  // Output stage: capture on accept, drain when the consumer takes the word, drop everything on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      rr_ptr <= rr_ptr_next;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[accept_idx];
        out_chan  <= accept_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
Parametrised N:1 data multiplexer with a registered output and valid/ready handshakes on every input channel and on the output. It runs in one of two modes. In fixed mode, a select input picks the channel, as in the combinational 2:1 and 4:1 muxes. In round-robin mode, an internal pointer arbitrates fairly among the valid channels. It sits between multiple producers and a single consumer in the datapath.

Parameters:
WIDTH, 8, data width per channel in bits
N, 4, number of input channels, 2..16; need not be a power of two
SEL_W, $clog2(N), localparam; width of the select and channel-index fields

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
out_data  output  WIDTH  registered data
out_chan  output  SEL_W  channel index of the word in out_data
out_valid  output  1  registered valid
out_ready  input  1  consumer ready

Behaviour:
- Reset: rst_n sampled low at a clk edge gives out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
- Reset mid-operation: any held word is dropped. No input transfer completes in that cycle.
- Output stage has two states, set by out_valid:
  - EMPTY (out_valid=0) -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and no new accept in that cycle.
  - FULL -> FULL when out_ready=1 and accept in the same cycle. This pass-through gives full throughput, 1 word per cycle.
- load = !out_valid || out_ready.
- Fixed mode (mode=0):
  - in_ready[sel] = load. All other in_ready bits = 0.
  - If sel >= N, all in_ready = 0 and nothing is accepted.
- Round-robin mode (mode=1):
  - grant = first index i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap at N-1 -> 0.
  - in_ready[grant] = load when any in_valid is 1. All other in_ready bits = 0.
- Accept happens when in_valid[k] && in_ready[k]. At that clk edge:
  - out_data <= channel k data, out_chan <= k, out_valid <= 1.
  - In round-robin mode only: rr_ptr <= (k == N-1) ? 0 : k+1.
- rr_ptr is unchanged in fixed mode and on cycles with no accept.
- Latency: 1 cycle from accept to out_valid=1.
- While out_valid=1 && out_ready=0, out_data and out_chan hold stable and all in_ready = 0.
- Producers must hold in_data and in_valid stable until accepted. The block does not check this.
- mode or sel change: takes effect in the same cycle's arbitration. A word already held is unaffected.
- At most one in_ready bit is high per cycle, so at most one accept per cycle.

Decomposition:
- Package mux_pkg: mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1, plus a max-N constant (16) for parameter checks.
- One sub-module, rr_priority_pick: combinational rotate-priority encoder.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Must handle non-power-of-two N, with wrap at N-1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout; first accept occurs on the cycle after release.
- Fixed mode: N=4, sel=2, ch2 data 8'hA5 valid, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_chan=2. Set sel=3 with ch3 idle -> out_valid drops the following cycle.
- Round-robin fairness: all 4 channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1; one word per cycle with no bubbles.
- Round-robin skip and wrap: only ch1 and ch3 valid, rr_ptr=2 -> grants 3,1,3,1. With N=3 and all channels valid -> 0,1,2,0 (wrap at 2).
- Backpressure: out_ready=0 for 3 cycles while FULL with 8'h3C -> out_data stays 8'h3C, all in_ready=0, rr_ptr frozen. Raising out_ready gives a pass-through accept in the same cycle.
- Mode switch and mid-reset: switch from round-robin to fixed with sel=0 while FULL -> held word is unchanged and the next accept comes from ch0. Assert rst_n=0 while FULL -> next cycle out_valid=0 and rr_ptr=0.
